// File: rtl/conv3x3_stream_filter_if.sv
// Pixel stream handshake bundle: valid/ready transfer with a start-of-frame marker.
interface conv3x3_stream_filter_if #(
    parameter int DW = 12
);
    logic          valid;
    logic          ready;
    logic          sof;
    logic [DW-1:0] data;

    modport master (output valid, output sof, output data, input ready);
    modport slave  (input valid, input sof, input data, output ready);
endinterface

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 neighbourhood filter (bypass/gaussian/sharpen/edge) with border pass-through.
// Define CONV3X3_ROUND_EN to round the gaussian result half up instead of truncating.
module conv3x3_stream_filter #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     mode,
    conv3x3_stream_filter_if.slave         in_if,
    conv3x3_stream_filter_if.master        out_if
);
    localparam int DW = NUM_CH * CH_W;
    localparam int LW = $clog2(IMG_W);
    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = CH_W + 5;
    localparam logic signed [AW-1:0] MAXV = AW'((1 << CH_W) - 1);
    localparam logic signed [AW-1:0] RND  = 8;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic                   rdy_en_q;
    logic [1:0]             mode_q;
    logic [LW-1:0]          in_col_q, out_col_q;
    logic [RW-1:0]          in_row_q, out_row_q;
    logic [CW-1:0]          fc_q;
    logic                   v1_q;
    logic [1:0]             f_cnt_q;
    logic [1:0][DW-1:0]     f_data_q;
    logic [1:0]             f_sof_q;
    logic [8:0][DW-1:0]     win_q;
    logic [DW-1:0]          lb0_q [IMG_W];
    logic [DW-1:0]          lb1_q [IMG_W];

    logic                   in_rdy, acc, sof_acc, can_adv, flush_step, shift, produce;
    logic                   push, pop, in_last_col, in_last_row, border;
    logic [LW-1:0]          lx;
    logic [DW-1:0]          pix_in, top, mid, filt, res;
    logic [9*CH_W-1:0]      wv;

    function automatic logic signed [AW-1:0] ext(input logic [CH_W-1:0] x);
        return $signed({5'b0, x});
    endfunction

    function automatic logic [CH_W-1:0] clamp(input logic signed [AW-1:0] v);
        if (v < 0) return '0;
        else if (v > MAXV) return '1;
        else return v[CH_W-1:0];
    endfunction

    // p holds the 3x3 neighbourhood of one channel, row-major, index 4 = centre
    function automatic logic [CH_W-1:0] filt_ch(input logic [1:0] m, input logic [9*CH_W-1:0] p);
        logic signed [AW-1:0] c, orth, corn, g;
        c    = ext(p[4*CH_W +: CH_W]);
        orth = ext(p[1*CH_W +: CH_W]) + ext(p[3*CH_W +: CH_W])
             + ext(p[5*CH_W +: CH_W]) + ext(p[7*CH_W +: CH_W]);
        corn = ext(p[0*CH_W +: CH_W]) + ext(p[2*CH_W +: CH_W])
             + ext(p[6*CH_W +: CH_W]) + ext(p[8*CH_W +: CH_W]);
`ifdef CONV3X3_ROUND_EN
        g = corn + (orth <<< 1) + (c <<< 2) + RND;
`else
        g = corn + (orth <<< 1) + (c <<< 2);
`endif
        case (m)
            2'd1:    return g[CH_W+3:4];
            2'd2:    return clamp((c <<< 2) + c - orth);
            2'd3: begin
                g = (c <<< 2) - orth;
                return clamp((g < 0) ? -g : g);
            end
            default: return c[CH_W-1:0];
        endcase
    endfunction

    assign can_adv     = !v1_q || (f_cnt_q != 2'd2);
    assign acc         = in_if.valid && in_rdy;
    assign sof_acc     = acc && in_if.sof;
    assign in_last_col = (in_col_q == LW'(IMG_W - 1));
    assign in_last_row = (in_row_q == RW'(IMG_H - 1));
    assign flush_step  = (state_q == FLUSH) && (fc_q != CW'(IMG_W + 1)) && can_adv;
    assign shift       = !reset && (sof_acc || (acc && state_q != IDLE) || flush_step);
    assign produce     = (acc && !in_if.sof && state_q == RUN) || flush_step;
    assign push        = v1_q && (f_cnt_q != 2'd2);
    assign pop         = out_if.valid && out_if.ready;

    // Flush replays dummy beats so the remaining centres slide through the window
    assign lx     = sof_acc ? '0 :
                    (state_q == FLUSH) ? ((fc_q < CW'(IMG_W)) ? LW'(fc_q) : '0) : in_col_q;
    assign pix_in = (state_q == FLUSH) ? '0 : in_if.data;
    assign top    = lb1_q[lx];
    assign mid    = lb0_q[lx];

    always_comb begin
        filt = '0;
        wv   = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned k = 0; k < 9; k++)
                wv[k*CH_W +: CH_W] = win_q[k][ch*CH_W +: CH_W];
            filt[ch*CH_W +: CH_W] = filt_ch(mode_q, wv);
        end
    end

    assign border = (out_row_q == '0) || (out_row_q == RW'(IMG_H - 1)) ||
                    (out_col_q == '0) || (out_col_q == LW'(IMG_W - 1));
    assign res    = (border || mode_q == 2'd0) ? win_q[4] : filt;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (sof_acc) state_d = FILL;
            FILL:  if (sof_acc) state_d = FILL;
                   else if (acc && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
            RUN:   if (sof_acc) state_d = FILL;
                   else if (acc && in_last_row && in_last_col) state_d = FLUSH;
            FLUSH: if (fc_q == CW'(IMG_W + 1) && !v1_q && f_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            IDLE:     in_rdy = rdy_en_q;
            FILL,
            RUN:      in_rdy = rdy_en_q && can_adv;
            default:  in_rdy = 1'b0;
        endcase
    end

    assign in_if.ready  = in_rdy;
    assign out_if.valid = (f_cnt_q != '0);
    assign out_if.sof   = f_sof_q[0] && (f_cnt_q != '0);
    assign out_if.data  = f_data_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en_q  <= 1'b0;
            mode_q    <= '0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            fc_q      <= '0;
            v1_q      <= 1'b0;
            f_cnt_q   <= '0;
            f_data_q  <= '0;
            f_sof_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (sof_acc) mode_q <= mode;
            if (sof_acc) begin
                in_col_q <= LW'(1);
                in_row_q <= '0;
            end else if (acc && state_q != IDLE) begin
                if (in_last_col) begin
                    in_col_q <= '0;
                    in_row_q <= in_row_q + RW'(1);
                end else begin
                    in_col_q <= in_col_q + LW'(1);
                end
            end
            if (state_q != FLUSH) fc_q <= '0;
            else if (flush_step)  fc_q <= fc_q + CW'(1);
            // A new sof discards the in-flight window result and the skid contents
            if (sof_acc) begin
                v1_q      <= 1'b0;
                f_cnt_q   <= '0;
                out_col_q <= '0;
                out_row_q <= '0;
            end else begin
                if (produce)   v1_q <= 1'b1;
                else if (push) v1_q <= 1'b0;
                if (push) begin
                    if (out_col_q == LW'(IMG_W - 1)) begin
                        out_col_q <= '0;
                        out_row_q <= out_row_q + RW'(1);
                    end else begin
                        out_col_q <= out_col_q + LW'(1);
                    end
                end
                case ({push, pop})
                    2'b10: begin
                        if (f_cnt_q == '0) begin
                            f_data_q[0] <= res;
                            f_sof_q[0]  <= border && out_row_q == '0 && out_col_q == '0;
                        end else begin
                            f_data_q[1] <= res;
                            f_sof_q[1]  <= border && out_row_q == '0 && out_col_q == '0;
                        end
                        f_cnt_q <= f_cnt_q + 2'd1;
                    end
                    2'b01: begin
                        f_data_q[0] <= f_data_q[1];
                        f_sof_q[0]  <= f_sof_q[1];
                        f_cnt_q     <= f_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        f_data_q[0] <= res;
                        f_sof_q[0]  <= border && out_row_q == '0 && out_col_q == '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win_q[i*3]     <= win_q[i*3 + 1];
                win_q[i*3 + 1] <= win_q[i*3 + 2];
            end
            win_q[2] <= top;
            win_q[5] <= mid;
            win_q[8] <= pix_in;
            if (state_q != FLUSH) begin
                lb1_q[lx] <= mid;
                lb0_q[lx] <= pix_in;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Scoreboard bench for conv3x3_stream_filter: directed frames, expected pixels queued at stimulus time.
module tb_conv3x3_stream_filter;
    localparam int W = 32, H = 24, DW = 12, NPIX = W * H;
    localparam int K_FLAT = 0, K_IMPG = 1, K_IMPS = 2, K_IMPE = 3, K_BYP = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode;
    exp_t       q[$];
    int         n_checks = 0, n_fail = 0;
    int         out_cnt = 0, sof_cnt = 0;
    bit         mon_en = 1'b1, rand_rdy = 1'b0, allow_resync = 1'b0;

    always #5 clk = ~clk;

    conv3x3_stream_filter_if #(.DW(DW)) in_if ();
    conv3x3_stream_filter_if #(.DW(DW)) out_if ();

    conv3x3_stream_filter #(.IMG_W(W), .IMG_H(H), .CH_W(4), .NUM_CH(3)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_if(in_if), .out_if(out_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] stim(input int kind, input int r, input int c);
        case (kind)
            K_FLAT:  return 12'hAAA;
            K_BYP:   return DW'((r * W + c) * 97 + 13);
            default: return (r == 5 && c == 5) ? 12'hF00 : 12'h000;
        endcase
    endfunction

    function automatic logic [DW-1:0] expv(input int kind, input int r, input int c);
        int ar, ac, v;
        ar = (r > 5) ? r - 5 : 5 - r;
        ac = (c > 5) ? c - 5 : 5 - c;
        v  = 0;
        case (kind)
            K_FLAT: return 12'hAAA;
            K_BYP:  return stim(kind, r, c);
            K_IMPG: begin
`ifdef CONV3X3_ROUND_EN
                if (ar == 0 && ac == 0) v = 4;
                else if (ar + ac == 1)  v = 2;
                else if (ar == 1 && ac == 1) v = 1;
`else
                if (ar == 0 && ac == 0) v = 3;
                else if (ar + ac == 1)  v = 1;
`endif
            end
            K_IMPS: if (ar == 0 && ac == 0) v = 15;
            K_IMPE: if (ar + ac <= 1) v = 15;
            default: v = 0;
        endcase
        return DW'(v << 8);
    endfunction

    always @(posedge clk) begin
        #1 out_if.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && out_if.valid && out_if.ready) begin
            out_cnt++;
            if (out_if.sof) sof_cnt++;
            if (allow_resync && out_if.sof)
                while (q.size() > 0 && !q[0].s) void'(q.pop_front());
            check("expected_output_present", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_data", 32'(out_if.data), 32'(e.d));
                check("out_sof", 32'(out_if.sof), 32'(e.s));
            end
        end
    end

    task automatic send_pixel(input logic [DW-1:0] d, input logic s, output bit ok);
        bit rdy;
        ok = 1'b0;
        in_if.valid = 1'b1;
        in_if.sof   = s;
        in_if.data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            rdy = in_if.ready;
            @(posedge clk);
            ok = rdy;
        end
        if (!ok) check("in_ready_timeout", 32'(rdy), 1);
        #1;
        in_if.valid = 1'b0;
        in_if.sof   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input logic [1:0] m, input int npix);
        bit   ok;
        exp_t e;
        int   j;
        for (int k = 0; k < npix; k++) begin
            if (k == 0) mode = m;
            send_pixel(stim(kind, k / W, k % W), k == 0, ok);
            if (k == 0) mode = ~m;
            if (ok && k >= W + 1) begin
                j   = k - W - 1;
                e.d = expv(kind, j / W, j % W);
                e.s = (j == 0);
                q.push_back(e);
            end
        end
        if (npix == NPIX) begin
            for (int jj = NPIX - W - 1; jj < NPIX; jj++) begin
                e.d = expv(kind, jj / W, jj % W);
                e.s = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(q.size()), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_and_check();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_if.valid), 0);
        check("rst_out_sof", 32'(out_if.sof), 0);
        check("rst_out_data", 32'(out_if.data), 0);
        check("rst_in_ready_low", 32'(in_if.ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready_high", 32'(in_if.ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        in_if.valid  = 1'b0;
        in_if.sof    = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        mode         = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset_and_check();

        // Non-sof beats while idle are swallowed without producing output
        send_pixel(12'h555, 1'b0, ok);
        send_pixel(12'h123, 1'b0, ok);

        out_cnt = 0;
        sof_cnt = 0;
        send_frame(K_FLAT, 2'd1, NPIX);
        drain();
        check("flat_output_count", 32'(out_cnt), NPIX);
        check("flat_sof_count", 32'(sof_cnt), 1);

        send_frame(K_IMPG, 2'd1, NPIX);
        drain();
        send_frame(K_IMPS, 2'd2, NPIX);
        drain();
        send_frame(K_IMPE, 2'd3, NPIX);
        drain();

        rand_rdy = 1'b1;
        send_frame(K_BYP, 2'd0, NPIX);
        drain();
        send_frame(K_IMPE, 2'd3, NPIX);
        drain();
        rand_rdy = 1'b0;

        allow_resync = 1'b1;
        send_frame(K_BYP, 2'd0, 500);
        send_frame(K_IMPS, 2'd2, NPIX);
        drain();
        allow_resync = 1'b0;

        send_frame(K_BYP, 2'd0, 300);
        mon_en = 1'b0;
        pulse_reset_and_check();
        q.delete();
        mon_en = 1'b1;
        send_frame(K_IMPE, 2'd3, NPIX);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
